// File: rtl/fifo_uart_tx_drain.sv
// Pops words from the FIFO read port and serialises them as UART frames (start, data LSB first, optional parity, stop).
// Latency: pop in cycle N, start bit on the line in cycle N+1; back-to-back frames are gap-free.
// Backpressure: pops only in IDLE or STOP when fifo_empty=0; an empty FIFO simply holds the line idle high.
module fifo_uart_tx_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  fifo_rinc,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_bit;
    logic                    par_en_q;
    logic [CNT_W-1:0]        bitcnt;
    logic                    pop;
    logic                    last_bit;
    logic                    tx_nxt;

    assign pop       = !rst && !fifo_empty && (state == IDLE || state == STOP);
    assign fifo_rinc = pop;
    assign last_bit  = (bitcnt == CNT_W'(DATA_WIDTH - 1));

    always_comb begin
        state_nxt = state;
        tx_nxt    = 1'b1;
        case (state)
            IDLE:    if (pop) state_nxt = START;
            START:   state_nxt = DATA;
            DATA:    if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = pop ? START : IDLE;
            default: state_nxt = IDLE;
        endcase

        // Line value is chosen for the state being entered so tx_out is registered with it.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg[0];
            PARITY:  tx_nxt = par_bit;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            par_en_q   <= 1'b0;
            bitcnt     <= '0;
        end else begin
            state      <= state_nxt;
            tx_out     <= tx_nxt;
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == STOP);

            if (pop) begin
                shreg    <= fifo_rdata;
                par_bit  <= (^fifo_rdata) ^ par_typ;
                par_en_q <= par_en;
            end else if (state_nxt == DATA) begin
                shreg    <= shreg >> 1;
            end

            if (state == DATA) begin
                bitcnt <= bitcnt + CNT_W'(1);
            end else begin
                bitcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: a queue-backed FIFO feeds the DUT and each cycle is compared
// against a per-cycle line/busy/frame_done/pop schedule built from the framing rules.
module tb_fifo_uart_tx_drain;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          par_en;
    logic          par_typ;
    logic          fifo_rinc;
    logic          tx_out;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx_drain #(.DATA_WIDTH(DW), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .fifo_rinc  (fifo_rinc),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] wq[$];
    logic          ex_tx[$];
    logic          ex_busy[$];
    logic          ex_fd[$];
    logic          ex_rinc[$];

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : DW'($urandom);
    endtask

    task automatic push_exp(input logic t, input logic b, input logic f, input logic r);
        ex_tx.push_back(t);
        ex_busy.push_back(b);
        ex_fd.push_back(f);
        ex_rinc.push_back(r);
    endtask

    task automatic chk_idle(input string tag, input int cyc);
        chk({tag, "_tx"},   cyc, tx_out,     1'b1);
        chk({tag, "_busy"}, cyc, busy,       1'b0);
        chk({tag, "_fd"},   cyc, frame_done, 1'b0);
        chk({tag, "_rinc"}, cyc, fifo_rinc,  1'b0);
    endtask

    // Sends the words in wq starting from idle; abort_at >= 0 asserts rst after that cycle's checks.
    task automatic run_seq(input logic pe, input logic pt, input int abort_at);
        logic [DW-1:0] w;
        logic          pop_now;
        bit            aborted;
        aborted = 0;
        ex_tx.delete(); ex_busy.delete(); ex_fd.delete(); ex_rinc.delete();
        push_exp(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            push_exp(1'b0, 1'b1, 1'b0, 1'b0);
            for (int b = 0; b < DW; b++) push_exp(w[b], 1'b1, 1'b0, 1'b0);
            if (pe) push_exp((^w) ^ pt, 1'b1, 1'b0, 1'b0);
            push_exp(1'b1, 1'b1, 1'b1, (i < wq.size() - 1));
        end
        for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0, 1'b0, 1'b0);

        foreach (wq[i]) fq.push_back(wq[i]);
        par_en  = pe;
        par_typ = pt;
        drive_fifo();

        for (int c = 0; c < ex_tx.size(); c++) begin
            @(negedge clk);
            chk("rinc", c, fifo_rinc,  ex_rinc[c]);
            chk("tx",   c, tx_out,     ex_tx[c]);
            chk("busy", c, busy,       ex_busy[c]);
            chk("fd",   c, frame_done, ex_fd[c]);
            pop_now = fifo_rinc;
            if (c == abort_at) begin
                rst     = 1'b1;
                aborted = 1;
                break;
            end
            @(posedge clk);
            if (pop_now && fq.size() != 0) void'(fq.pop_front());
            #1;
            drive_fifo();
            // Configuration only matters at pop edges; scramble it everywhere else.
            if (c + 1 < ex_tx.size() && ex_rinc[c + 1]) begin
                par_en  = pe;
                par_typ = pt;
            end else begin
                par_en  = 1'($urandom);
                par_typ = 1'($urandom);
            end
        end

        if (aborted) begin
            @(posedge clk);
            if (fq.size() != 0) void'(fq.pop_front());
            #1;
            drive_fifo();
            @(negedge clk);
            chk_idle("abort", 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            fq.delete();
            drive_fifo();
            @(negedge clk);
            chk_idle("after_abort", 1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b0;
        fifo_rdata = '0;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        // Reset with a non-empty FIFO must not pop.
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("reset", 0);
        @(posedge clk); #1;
        rst = 1'b0;
        fifo_empty = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk_idle("idle", c);
            @(posedge clk); #1;
        end

        wq.delete(); wq.push_back(8'hA5);
        run_seq(1'b0, 1'b0, -1);
        wq.delete(); wq.push_back(8'hA5);
        run_seq(1'b1, 1'b0, -1);
        wq.delete(); wq.push_back(8'h01);
        run_seq(1'b1, 1'b0, -1);
        wq.delete(); wq.push_back(8'h01);
        run_seq(1'b1, 1'b1, -1);
        wq.delete(); wq.push_back(8'h00);
        run_seq(1'b1, 1'b1, -1);

        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
        run_seq(1'b0, 1'b0, -1);

        // Abort during data bit 4 of 0x5A, with a second word still waiting.
        wq.delete(); wq.push_back(8'h5A); wq.push_back(8'h3C);
        run_seq(1'b0, 1'b0, 6);
        wq.delete(); wq.push_back(8'h3C);
        run_seq(1'b1, 1'b1, -1);

        for (int k = 0; k < 10; k++) begin
            wq.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) wq.push_back(DW'($urandom));
            run_seq(1'($urandom), 1'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx_drain.md
Name: fifo_uart_tx_drain

Overview:
- Downstream consumer of the system FIFO's read port.
- Watches the FIFO empty flag and pops one word at a time. It uses the FIFO's asynchronous read data, which is valid in the same cycle as raddr.
- Serialises each word onto a UART TX line: one start bit, DATA_WIDTH data bits LSB first, an optional parity bit, and one stop bit. One bit per clk cycle; clk is already the bit-rate clock.
- Back-to-back frames are sent with no idle gap while the FIFO stays non-empty.

Parameters:
- DATA_WIDTH, 8, width of a FIFO word and of the serial data field.
- CNT_W, 3, bit-counter width; must satisfy 2^CNT_W >= DATA_WIDTH.

Ports:
- clk  input  1  single clock; the bit clock.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag; 1 = no word available.
- fifo_rdata  input  DATA_WIDTH  FIFO read data at the current raddr (async read).
- par_en  input  1  1 = insert a parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- fifo_rinc  output  1  pop strobe to the FIFO read pointer; one cycle per word.
- tx_out  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.
- frame_done  output  1  one-cycle pulse during a frame's stop-bit cycle.

Behaviour:
- Reset: when rst=1 at a clk edge:
  - state goes to IDLE.
  - tx_out=1, busy=0, frame_done=0.
  - fifo_rinc=0 combinationally while rst=1.
  - Reset mid-frame aborts the frame. No partial stop bit. The popped word is lost. No extra pop.
- States: IDLE, START, DATA, PARITY, STOP.
- Pop rule:
  - fifo_rinc = !rst && !fifo_empty && (state==IDLE || state==STOP).
  - This is the only source of fifo_rinc, so it is never high in START, DATA or PARITY.
- Load on pop, at the same edge:
  - shift register <= fifo_rdata.
  - parity bit <= ^fifo_rdata ^ par_typ.
  - par_en and par_typ are latched too; they are ignored mid-frame.
  - Next state is START.
- Line timing, with the pop in cycle N:
  - tx_out is registered.
  - tx_out=0 during cycle N+1 (START).
  - data bits in cycles N+2 .. N+1+DATA_WIDTH, LSB first.
  - if latched par_en: parity bit in cycle N+2+DATA_WIDTH.
  - stop bit tx_out=1 in the following cycle.
  - Frame length is DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
- Transitions:
  - IDLE -> START on pop.
  - START -> DATA.
  - DATA counts DATA_WIDTH bits, bit counter 0..DATA_WIDTH-1. On the last bit: go to PARITY if par_en is latched, otherwise STOP.
  - PARITY -> STOP.
  - STOP -> START if a pop occurs in the STOP cycle (back-to-back frames), otherwise IDLE.
- busy:
  - 1 in START, DATA, PARITY and STOP.
  - 0 in IDLE.
  - Stays 1 continuously across back-to-back frames.
- frame_done: 1 exactly during the STOP cycle, registered together with tx_out.
- Empty boundary:
  - fifo_empty=1 in IDLE: stay idle with tx_out=1.
  - fifo_empty rising mid-frame has no effect on that frame.
  - fifo_empty falling mid-frame is only acted on in the STOP cycle.
- fifo_rdata is sampled only at the pop edge. Changes at any other time are ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, fifo_empty=1 for 20 cycles -> tx_out=1, busy=0, fifo_rinc=0 throughout.
- Single frame, no parity: par_en=0, FIFO holds 0xA5, empty deasserts for 1 word -> one fifo_rinc pulse; tx_out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; frame_done high on the 10th; then idle.
- Even parity: par_en=1, par_typ=0, word 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,0,1 (parity 0), 11 cycles. Word 0x01 -> parity bit 1.
- Odd parity: par_en=1, par_typ=1, word 0x01 -> parity bit 0. Word 0x00 -> parity bit 1.
- Back-to-back: 3 words 0x11, 0x22, 0x33 queued, par_en=0 -> 3 fifo_rinc pulses, each in a STOP cycle except the first; 30 contiguous line cycles; busy never drops; 3 frame_done pulses exactly 10 cycles apart.
- Reset mid-frame, including mid-config change:
  - rst=1 during bit 4 of 0x5A -> tx_out=1 and busy=0 at the next edge; no further pop until rst=0 and fifo_empty=0.
  - Toggling par_en during DATA does not change the current frame's length.
